// File: rtl/jpeg_idct_pkg.sv
// Shared constants and index helpers for the IDCT transpose buffer.
package jpeg_idct_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BLK_N_DEF  = 8;

  function automatic int clog2(input int value);
    int res;
    int acc;
    res = 0;
    acc = 1;
    while (acc < value) begin
      acc = acc * 2;
      res = res + 1;
    end
    return res;
  endfunction

  // Swap the row and column fields of a {row, col} index, each half_w bits wide.
  function automatic logic [31:0] swap_idx(input logic [31:0] idx, input int half_w);
    logic [31:0] mask;
    mask = (32'd1 << half_w) - 32'd1;
    return ((idx & mask) << half_w) | ((idx >> half_w) & mask);
  endfunction

endpackage

// File: rtl/jpeg_tbuf_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module jpeg_tbuf_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port and registered read port; read-during-write returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_r[rd_addr_i];
    end
  end

endmodule

// File: rtl/jpeg_idct_transpose_buf.sv
// Double-buffered block transpose buffer between the IDCT row and column passes.
module jpeg_idct_transpose_buf
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BLK_N  = BLK_N_DEF,
  parameter int BANKS  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              inp_valid_i,
  input  logic [DATA_W-1:0] inp_data_i,
  input  logic              inp_transpose_i,
  output logic              inp_accept_o,
  output logic              outp_valid_o,
  output logic [DATA_W-1:0] outp_data_o,
  output logic              outp_last_o,
  input  logic              outp_accept_i,
  output logic              idle_o
);

  localparam int HALF_W = clog2(BLK_N);
  localparam int IDX_W  = 2 * HALF_W;
  localparam int BANK_W = clog2(BANKS);
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = BANKS * BLK_N * BLK_N;

  localparam logic [IDX_W-1:0]  IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [BANK_W-1:0] BANK_ZERO = {BANK_W{1'b0}};
  localparam logic [BANK_W-1:0] BANK_ONE  = {{(BANK_W-1){1'b0}}, 1'b1};
  localparam logic [BANKS-1:0]  BANK_LSB  = {{(BANKS-1){1'b0}}, 1'b1};

  logic [BANKS-1:0]  full_r;
  logic [BANKS-1:0]  mode_r;
  logic [BANK_W-1:0] wr_bank_r;
  logic [BANK_W-1:0] rd_bank_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic [IDX_W-1:0]  rd_idx_r;
  logic              pend_r;
  logic              pend_last_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [DATA_W-1:0] out_data_r;

  logic              accept_s;
  logic              wr_fire_s;
  logic              wr_done_s;
  logic              rd_fire_s;
  logic              rd_done_s;
  logic              pend_move_s;
  logic [BANKS-1:0]  full_nxt_s;
  logic [IDX_W-1:0]  rd_map_s;
  logic [DATA_W-1:0] ram_q_s;

  assign accept_s    = !full_r[wr_bank_r];
  assign wr_fire_s   = inp_valid_i && accept_s;
  assign wr_done_s   = wr_fire_s && (wr_idx_r == IDX_LAST);
  // The in-flight read advances whenever the output register is free or draining.
  assign pend_move_s = pend_r && (!out_valid_r || outp_accept_i);
  assign rd_fire_s   = full_r[rd_bank_r] && (!pend_r || !out_valid_r || outp_accept_i);
  assign rd_done_s   = rd_fire_s && (rd_idx_r == IDX_LAST);
  assign full_nxt_s  = (full_r | (wr_done_s ? (BANK_LSB << wr_bank_r) : {BANKS{1'b0}}))
                       & ~(rd_done_s ? (BANK_LSB << rd_bank_r) : {BANKS{1'b0}});

  // Read address mapping: swap row/col fields for column-major readout.
  always_comb begin
    rd_map_s = rd_idx_r;
    if (mode_r[rd_bank_r]) begin
      rd_map_s = IDX_W'(swap_idx(32'(rd_idx_r), HALF_W));
    end else begin
      rd_map_s = rd_idx_r;
    end
  end

  jpeg_tbuf_ram #(
    .WIDTH  (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_fire_s && !flush_i),
    .wr_addr_i ({wr_bank_r, wr_idx_r}),
    .wr_data_i (inp_data_i),
    .rd_en_i   (rd_fire_s && !flush_i),
    .rd_addr_i ({rd_bank_r, rd_map_s}),
    .rd_data_o (ram_q_s)
  );

  // Bank occupancy, per-bank readout mode, and write/read pointers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_r    <= {BANKS{1'b0}};
      mode_r    <= {BANKS{1'b0}};
      wr_bank_r <= BANK_ZERO;
      rd_bank_r <= BANK_ZERO;
      wr_idx_r  <= IDX_ZERO;
      rd_idx_r  <= IDX_ZERO;
    end else if (flush_i) begin
      full_r    <= {BANKS{1'b0}};
      mode_r    <= {BANKS{1'b0}};
      wr_bank_r <= BANK_ZERO;
      rd_bank_r <= BANK_ZERO;
      wr_idx_r  <= IDX_ZERO;
      rd_idx_r  <= IDX_ZERO;
    end else begin
      full_r <= full_nxt_s;
      if (wr_fire_s) begin
        wr_idx_r <= wr_idx_r + IDX_ONE;
        if (wr_idx_r == IDX_ZERO) begin
          mode_r[wr_bank_r] <= inp_transpose_i;
        end
        if (wr_done_s) begin
          wr_bank_r <= wr_bank_r + BANK_ONE;
        end
      end
      if (rd_fire_s) begin
        rd_idx_r <= rd_idx_r + IDX_ONE;
        if (rd_done_s) begin
          rd_bank_r <= rd_bank_r + BANK_ONE;
        end
      end
    end
  end

  // In-flight read tracking and the single output register stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      if (rd_fire_s) begin
        pend_r      <= 1'b1;
        pend_last_r <= (rd_idx_r == IDX_LAST);
      end else if (pend_move_s) begin
        pend_r <= 1'b0;
      end
      if (pend_move_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= ram_q_s;
        out_last_r  <= pend_last_r;
      end else if (out_valid_r && outp_accept_i) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign inp_accept_o = accept_s;
  assign outp_valid_o = out_valid_r;
  assign outp_data_o  = out_data_r;
  assign outp_last_o  = out_last_r;
  assign idle_o       = (full_r == {BANKS{1'b0}}) && !pend_r && !out_valid_r;

endmodule

// File: tb/tb_jpeg_idct_transpose_buf.sv
// Directed self-checking bench for jpeg_idct_transpose_buf (DATA_W=32, BLK_N=8, BANKS=2).
module tb_jpeg_idct_transpose_buf;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        inp_valid_i;
  logic [31:0] inp_data_i;
  logic        inp_transpose_i;
  logic        inp_accept_o;
  logic        outp_valid_o;
  logic [31:0] outp_data_o;
  logic        outp_last_o;
  logic        outp_accept_i;
  logic        idle_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_pct = 0;
  int last_in_cyc = -1;
  int first_v = -1;
  int n_ticks;

  logic [32:0] src_q[$];
  logic [32:0] got_q[$];

  jpeg_idct_transpose_buf #(.DATA_W(32), .BLK_N(8), .BANKS(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .inp_valid_i     (inp_valid_i),
    .inp_data_i      (inp_data_i),
    .inp_transpose_i (inp_transpose_i),
    .inp_accept_o    (inp_accept_o),
    .outp_valid_o    (outp_valid_o),
    .outp_data_o     (outp_data_o),
    .outp_last_o     (outp_last_o),
    .outp_accept_i   (outp_accept_i),
    .idle_o          (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [31:0] base, input logic mode, input int count);
    for (int k = 0; k < count; k++) src_q.push_back({mode, base + 32'(k)});
  endtask

  // One clock: drive from src_q, collect handshaken outputs, check hold stability.
  task automatic tick();
    logic take_in, take_out, held, hold_last;
    logic [31:0] hold_data;
    inp_valid_i = (src_q.size() != 0);
    if (inp_valid_i) {inp_transpose_i, inp_data_i} = src_q[0];
    else begin
      inp_transpose_i = 1'b0;
      inp_data_i = 32'd0;
    end
    if (stall_pct == 0) outp_accept_i = 1'b1;
    else if (stall_pct >= 100) outp_accept_i = 1'b0;
    else outp_accept_i = ($urandom_range(0, 99) >= stall_pct);
    take_in  = inp_valid_i && inp_accept_o;
    take_out = outp_valid_o && outp_accept_i;
    held      = outp_valid_o && !outp_accept_i;
    hold_data = outp_data_o;
    hold_last = outp_last_o;
    if (take_out) got_q.push_back({outp_last_o, outp_data_o});
    @(posedge clk_i);
    #1;
    cyc++;
    if (take_in) begin
      if (src_q.size() == 1) last_in_cyc = cyc;
      void'(src_q.pop_front());
    end
    if (outp_valid_o && first_v < 0) first_v = cyc;
    if (held) begin
      check("hold_valid", 64'(outp_valid_o), 64'd1);
      check("hold_data", 64'(outp_data_o), 64'(hold_data));
      check("hold_last", 64'(outp_last_o), 64'(hold_last));
    end
  endtask

  task automatic run_until(input string tag, input int want, input int budget);
    n_ticks = 0;
    while (got_q.size() < want && n_ticks < budget) begin
      tick();
      n_ticks++;
    end
    check(tag, 64'(got_q.size()), 64'(want));
  endtask

  // Compare one block of collected output against the row/col model.
  task automatic check_block(input string tag, input int off, input logic [31:0] base, input logic mode);
    logic [32:0] exp;
    int r, c;
    for (int k = 0; k < 64; k++) begin
      r = k / 8;
      c = k % 8;
      exp[31:0] = mode ? (base + 32'(c * 8 + r)) : (base + 32'(k));
      exp[32]   = (k == 63);
      if (off + k < got_q.size()) check(tag, 64'(got_q[off + k]), 64'(exp));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(outp_valid_o), 64'd0);
    check({tag, "_last"}, 64'(outp_last_o), 64'd0);
    check({tag, "_data"}, 64'(outp_data_o), 64'd0);
    check({tag, "_accept"}, 64'(inp_accept_o), 64'd1);
    check({tag, "_idle"}, 64'(idle_o), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    inp_valid_i = 1'b0;
    inp_data_i = 32'd0;
    inp_transpose_i = 1'b0;
    outp_accept_i = 1'b1;
    #2 rst_i = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Transpose block with latency check
    first_v = -1;
    push_block(32'd0, 1'b1, 64);
    run_until("t1_count", 64, 300);
    check_block("t1_data", 0, 32'd0, 1'b1);
    check("t1_latency", 64'(first_v - last_in_cyc), 64'd2);

    // Passthrough block
    got_q.delete();
    push_block(32'd100, 1'b0, 64);
    run_until("t2_count", 64, 300);
    check_block("t2_data", 0, 32'd100, 1'b0);
    check("t2_idle", 64'(idle_o), 64'd1);

    // Backpressure: three blocks into two banks with output stalled
    got_q.delete();
    stall_pct = 100;
    push_block(32'd1000, 1'b1, 64);
    push_block(32'd2000, 1'b0, 64);
    push_block(32'd3000, 1'b1, 64);
    for (int i = 0; i < 300; i++) tick();
    check("t3_taken", 64'(192 - src_q.size()), 64'd128);
    check("t3_accept_low", 64'(inp_accept_o), 64'd0);
    check("t3_valid_held", 64'(outp_valid_o), 64'd1);
    check("t3_none_out", 64'(got_q.size()), 64'd0);
    stall_pct = 0;
    run_until("t3_count", 192, 600);
    check_block("t3_blk0", 0, 32'd1000, 1'b1);
    check_block("t3_blk1", 64, 32'd2000, 1'b0);
    check_block("t3_blk2", 128, 32'd3000, 1'b1);

    // Random output stalls over ten blocks of continuous input
    got_q.delete();
    stall_pct = 50;
    for (int b = 0; b < 10; b++) push_block(32'h10000 * 32'(b + 1), b[0] ? 1'b0 : 1'b1, 64);
    run_until("t4_count", 640, 6000);
    for (int b = 0; b < 10; b++) check_block("t4_data", b * 64, 32'h10000 * 32'(b + 1), b[0] ? 1'b0 : 1'b1);
    stall_pct = 0;

    // Flush while block 1 drains and block 2 is partially written
    got_q.delete();
    push_block(32'd5000, 1'b1, 64);
    push_block(32'd6000, 1'b0, 20);
    n_ticks = 0;
    while (src_q.size() != 0 && n_ticks < 300) begin
      tick();
      n_ticks++;
    end
    check("t5_fed", 64'(src_q.size()), 64'd0);
    check("t5_draining", 64'(outp_valid_o), 64'd1);
    flush_i = 1'b1;
    inp_valid_i = 1'b0;
    outp_accept_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check_reset_outputs("t5_flush");
    got_q.delete();
    push_block(32'd0, 1'b1, 64);
    run_until("t5_count", 64, 300);
    check_block("t5_data", 0, 32'd0, 1'b1);

    // Asynchronous reset mid-readout
    got_q.delete();
    push_block(32'd7000, 1'b0, 64);
    run_until("t6_partial", 10, 300);
    #3 rst_i = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    src_q.delete();
    inp_valid_i = 1'b0;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("t6_idle_after", 64'(idle_o), 64'd1);
    got_q.delete();
    first_v = -1;
    push_block(32'd0, 1'b1, 64);
    run_until("t6_count", 64, 300);
    check_block("t6_data", 0, 32'd0, 1'b1);
    check("t6_latency", 64'(first_v - last_in_cyc), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
